// File: rtl/booth_multiplier_m2.sv
// Radix-4 Booth multiplier for 4-bit signed operands producing an 8-bit signed product.
// Two recoding iterations per operation; the result is held in DONE until start drops.
module booth_multiplier_m2 (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [7:0] P,
    output logic       ready
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  mcand_q, mcand_d;
    logic [3:0]  mplier_q, mplier_d;
    logic [7:0]  acc_q, acc_d;
    logic        cnt_q, cnt_d;
    logic [7:0]  p_q, p_d;
    logic        ready_q, ready_d;

    logic [2:0]  triplet;
    logic [7:0]  pp;
    logic [7:0]  pp_shifted;
    logic [7:0]  sum;

    function automatic logic [7:0] booth_pp(input logic [2:0] trip, input logic [7:0] m);
        logic [7:0] r;
        r = 8'h00;
        case (trip)
            3'b000, 3'b111: r = 8'h00;
            3'b001, 3'b010: r = m;
            3'b011:         r = {m[6:0], 1'b0};
            3'b100:         r = ~{m[6:0], 1'b0} + 8'd1;
            3'b101, 3'b110: r = ~m + 8'd1;
            default:        r = 8'h00;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        ready_d  = ready_q;

        // Iteration 0 uses the implicit B[-1] = 0.
        triplet    = cnt_q ? mplier_q[3:1] : {mplier_q[1:0], 1'b0};
        pp         = booth_pp(triplet, mcand_q);
        pp_shifted = cnt_q ? {pp[5:0], 2'b00} : pp;
        sum        = acc_q + pp_shifted;

        case (state_q)
            StIdle: begin
                ready_d = 1'b0;
                if (start) begin
                    mcand_d  = {{4{A[3]}}, A};
                    mplier_d = B;
                    acc_d    = 8'h00;
                    cnt_d    = 1'b0;
                    state_d  = StCalc;
                end
            end
            StCalc: begin
                acc_d = sum;
                cnt_d = 1'b1;
                if (cnt_q) begin
                    p_d     = sum;
                    ready_d = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (!start) begin
                    ready_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                ready_d = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            mcand_q  <= 8'h00;
            mplier_q <= 4'h0;
            acc_q    <= 8'h00;
            cnt_q    <= 1'b0;
            p_q      <= 8'h00;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            ready_q  <= ready_d;
        end
    end

    assign P     = p_q;
    assign ready = ready_q;

endmodule

// File: tb/tb_booth_multiplier_m2.sv
// Scoreboard bench for booth_multiplier_m2: stimulus pushes expected products,
// a monitor pops and compares on each rising edge of ready.
module tb_booth_multiplier_m2;

    logic       clock;
    logic       reset;
    logic       start;
    logic [3:0] A;
    logic [3:0] B;
    logic [7:0] P;
    logic       ready;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] last_p;
    logic       stim_done = 1'b0;

    booth_multiplier_m2 dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .A     (A),
        .B     (B),
        .P     (P),
        .ready (ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %02h, required %02h", name, act, req);
        end
    endtask

    // Monitor: compare P against the scoreboard whenever ready rises.
    initial begin
        logic ready_prev;
        logic [7:0] e;
        ready_prev = 1'b0;
        forever begin
            @(negedge clock);
            if (ready === 1'b1 && ready_prev !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_ready: got P=%02h, required no result", P);
                end else begin
                    e = exp_q.pop_front();
                    chk("scoreboard_P", P, e);
                end
            end
            ready_prev = ready;
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        @(negedge clock);
        chk("reset_P", P, 8'h00);
        chk("reset_ready", {7'd0, ready}, 8'h00);
        reset  = 1'b0;
        last_p = 8'h00;
    endtask

    // Called at a negedge with the DUT in IDLE.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [7:0] req,
                          input int hold, input bit perturb);
        A     = a;
        B     = b;
        start = 1'b1;
        exp_q.push_back(req);
        @(negedge clock);
        if (perturb) begin
            A = ~a;
            B = b + 4'd5;
        end
        chk("calc0_ready", {7'd0, ready}, 8'h00);
        chk("calc0_P_held", P, last_p);
        @(negedge clock);
        chk("calc1_ready", {7'd0, ready}, 8'h00);
        chk("calc1_P_held", P, last_p);
        @(negedge clock);
        chk("done_ready", {7'd0, ready}, 8'h01);
        chk("done_P", P, req);
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            chk("hold_ready", {7'd0, ready}, 8'h01);
            chk("hold_P", P, req);
        end
        start = 1'b0;
        @(negedge clock);
        chk("drop_ready", {7'd0, ready}, 8'h00);
        chk("drop_P_kept", P, req);
        last_p = req;
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] p;
    } vec_t;

    vec_t vecs[7] = '{
        '{4'h1, 4'h3, 8'h03},
        '{4'h1, 4'hD, 8'hFD},
        '{4'hF, 4'h3, 8'hFD},
        '{4'hF, 4'hD, 8'h03},
        '{4'h8, 4'h8, 8'h40},
        '{4'h8, 4'h7, 8'hC8},
        '{4'h7, 4'h7, 8'h31}
    };

    initial begin
        int w;
        logic [7:0] ref_p;
        reset = 1'b1;
        start = 1'b0;
        A     = 4'h0;
        B     = 4'h0;
        last_p = 8'h00;
        repeat (3) @(negedge clock);

        foreach (vecs[i]) begin
            do_reset();
            run_op(vecs[i].a, vecs[i].b, vecs[i].p, 0, 1'b0);
        end

        // Operands altered after the load edge must not matter.
        do_reset();
        run_op(4'h5, 4'hA, 8'hE2, 0, 1'b1);

        // Hold start in DONE for several cycles.
        do_reset();
        run_op(4'h6, 4'h3, 8'h12, 4, 1'b0);

        // Abort mid-CALC with start still held.
        do_reset();
        A     = 4'h3;
        B     = 4'h5;
        start = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("abort_P", P, 8'h00);
        chk("abort_ready", {7'd0, ready}, 8'h00);
        reset = 1'b0;
        start = 1'b0;
        repeat (3) begin
            @(negedge clock);
            chk("abort_idle_ready", {7'd0, ready}, 8'h00);
            chk("abort_idle_P", P, 8'h00);
        end
        last_p = 8'h00;
        run_op(4'h2, 4'hE, 8'hFC, 0, 1'b0);

        // Exhaustive sweep, back-to-back without reset.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                ref_p = 8'($signed(4'(a)) * $signed(4'(b)));
                run_op(4'(a), 4'(b), ref_p, 0, 1'b0);
            end
        end

        w = 0;
        while (exp_q.size() != 0 && w < 20) begin
            @(negedge clock);
            w++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        stim_done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        if (!stim_done) begin
            $display("FAIL timeout: got no completion, required finish");
            $fatal(1, "timeout");
        end
    end

endmodule
